// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder and its byte-stream loader.
// The optional IMEM_PARITY_EN macro (used by the top) adds per-word even parity.
package imem_pkg;

   localparam int IMEM_DATA_WIDTH = 32;
   localparam int BYTES_PER_WORD  = IMEM_DATA_WIDTH / 8;
   localparam logic [IMEM_DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2,
      RUN  = 2'd3
   } imem_ld_state_t;

endpackage

// File: rtl/imem_loader_responder_byte_assembler.sv
// Collects accepted load bytes little-endian into one word; flags the word on its last byte.
module byte_assembler
   import imem_pkg::*;
#(
   parameter int P_DATA_WIDTH = IMEM_DATA_WIDTH
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    clear_i,
   input  logic                    accept_i,
   input  logic [7:0]              byte_i,
   output logic [P_DATA_WIDTH-1:0] word_o,
   output logic                    word_valid_o
);

   localparam int NB = P_DATA_WIDTH / 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   logic [IW-1:0]           idx_q, idx_d;
   logic [P_DATA_WIDTH-1:0] word_q, word_d;

   // The completed word is presented combinationally so the RAM write lands on the 4th-byte edge.
   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (accept_i) begin
         for (int k = 0; k < NB; k++) begin
            if (idx_q == IW'(k)) word_d[8*k +: 8] = byte_i;
         end
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;
      end
   end

   assign word_o       = word_d;
   assign word_valid_o = accept_i && !clear_i && (idx_q == LAST_IDX);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/imem_loader_responder.sv
// Instruction RAM with asynchronous fetch read plus a byte-stream program loader that holds the core
// until loading completes. Define IMEM_PARITY_EN to store and check one even-parity bit per word.
module imem_loader_responder
   import imem_pkg::*;
#(
   parameter int P_DATA_WIDTH = IMEM_DATA_WIDTH,
   parameter int PC_WIDTH     = 11
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [PC_WIDTH-1:0]     i_imem_addr,
   output logic [P_DATA_WIDTH-1:0] o_imem_rdata,
   output logic                    o_imem_err,
   input  logic                    i_ld_start,
   input  logic [PC_WIDTH-2:0]     i_ld_len,
   input  logic                    i_ld_valid,
   input  logic [7:0]              i_ld_byte,
   output logic                    o_ld_ready,
   output logic                    o_ld_done,
   output logic [PC_WIDTH-2:0]     o_ld_count,
   output logic                    o_core_hold
);

   localparam int P_DEPTH = 2 ** (PC_WIDTH - 2);
   localparam int CW      = PC_WIDTH - 1;
   localparam logic [CW-1:0] LEN_MAX = CW'(P_DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   imem_ld_state_t state_q, state_d;
   logic [CW-1:0]  len_q, len_d;
   logic [CW-1:0]  count_q, count_d;
   logic [CW-1:0]  len_clamped;
   logic           start_ok, accept, we;
   logic [P_DATA_WIDTH-1:0] asm_word;
   logic           asm_word_valid;

   logic [P_DATA_WIDTH-1:0] mem_q [P_DEPTH];
   logic [P_DATA_WIDTH-1:0] rd_word;
   logic                    unused_addr_lsbs;

   assign len_clamped = (i_ld_len > LEN_MAX) ? LEN_MAX : i_ld_len;

   byte_assembler #(.P_DATA_WIDTH(P_DATA_WIDTH)) u_asm (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .clear_i      (start_ok),
      .accept_i     (accept),
      .byte_i       (i_ld_byte),
      .word_o       (asm_word),
      .word_valid_o (asm_word_valid)
   );

   // Loader handshake: a byte moves when i_ld_valid and o_ld_ready are both high at the rising edge;
   // o_ld_ready depends only on state, never on i_ld_valid.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      count_d  = count_q;
      start_ok = 1'b0;
      accept   = 1'b0;
      we       = 1'b0;
      case (state_q)
         IDLE, RUN: begin
            if (i_ld_start) begin
               start_ok = 1'b1;
               count_d  = '0;
               len_d    = len_clamped;
               state_d  = (len_clamped == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            accept = i_ld_valid;
            if (asm_word_valid) begin
               we      = 1'b1;
               count_d = count_q + CNT_ONE;
               if (count_d == len_q) state_d = DONE;
            end
         end
         DONE:    state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         count_q <= count_d;
      end
   end

   // RAM contents are deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (we) mem_q[count_q[PC_WIDTH-3:0]] <= asm_word;
   end

   assign rd_word          = mem_q[i_imem_addr[PC_WIDTH-1:2]];
   assign unused_addr_lsbs = ^i_imem_addr[1:0];
   assign o_imem_rdata     = (state_q == LOAD) ? P_DATA_WIDTH'(NOP_INSTR) : rd_word;

`ifdef IMEM_PARITY_EN
   logic par_q [P_DEPTH];

   always_ff @(posedge i_clk) begin
      if (we) par_q[count_q[PC_WIDTH-3:0]] <= ^asm_word;
   end

   assign o_imem_err = (state_q != LOAD) && ((^rd_word) != par_q[i_imem_addr[PC_WIDTH-1:2]]);
`else
   assign o_imem_err = 1'b0;
`endif

   assign o_ld_ready  = (state_q == LOAD);
   assign o_ld_done   = (state_q == DONE);
   assign o_core_hold = (state_q != RUN);
   assign o_ld_count  = count_q;

endmodule
